// File: rtl/ped_signal_controller_if.sv
// Phase inputs, push-button and lamp/countdown outputs of the pedestrian crossing stage.
// master: traffic-side/bench driver; slave: ped_signal_controller.
interface ped_signal_controller_if #(
    parameter int CNT_W = 4
);
    logic             red;
    logic             yellow;
    logic             green;
    logic             ped_btn;
    logic             walk;
    logic             dont_walk;
    logic             ped_ack;
    logic [CNT_W-1:0] countdown;
    logic             fault;

    modport master (
        output red, yellow, green, ped_btn,
        input  walk, dont_walk, ped_ack, countdown, fault
    );

    modport slave (
        input  red, yellow, green, ped_btn,
        output walk, dont_walk, ped_ack, countdown, fault
    );
endinterface

// File: rtl/ped_signal_controller.sv
// Pedestrian crossing controller: serves a latched request inside a vehicle red phase.
// Define PED_AUTO_EN to start a walk on every red rising edge, with or without a request.
module ped_signal_controller #(
    parameter int TICK_DIV   = 100_000_000,
    parameter int WALK_SECS  = 7,
    parameter int FLASH_SECS = 5,
    parameter int CNT_W      = 4
) (
    input logic                     clk,
    input logic                     reset,
    ped_signal_controller_if.slave  bus
);
    localparam int unsigned PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SEC_W = $clog2(WALK_SECS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RED,
        S_WALK,
        S_FLASH,
        S_CLEAR
    } state_t;

    state_t             state_q, state_d;
    logic               btn_meta_q, btn_sync_q, btn_prev_q;
    logic               red_q, yellow_q, green_q, red_prev_q;
    logic               primed_q;
    logic               req_q, req_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [SEC_W-1:0]   sec_q, sec_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               walk_q, walk_d;
    logic               dw_q, dw_d;
    logic               fault_q, fault_d;

    logic               btn_edge;
    logic               red_rise;
    logic               phase_bad;
    logic               tick;
    logic               auto_go;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            btn_prev_q <= 1'b0;
            red_q      <= 1'b0;
            yellow_q   <= 1'b0;
            green_q    <= 1'b0;
            red_prev_q <= 1'b0;
            primed_q   <= 1'b0;
        end else begin
            btn_meta_q <= bus.ped_btn;
            btn_sync_q <= btn_meta_q;
            btn_prev_q <= btn_sync_q;
            red_q      <= bus.red;
            yellow_q   <= bus.yellow;
            green_q    <= bus.green;
            red_prev_q <= red_q;
            primed_q   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            pre_q   <= '0;
            sec_q   <= '0;
            cnt_q   <= '0;
            walk_q  <= 1'b0;
            dw_q    <= 1'b1;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            pre_q   <= pre_d;
            sec_q   <= sec_d;
            cnt_q   <= cnt_d;
            walk_q  <= walk_d;
            dw_q    <= dw_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        btn_edge  = btn_sync_q & ~btn_prev_q;
        red_rise  = red_q & ~red_prev_q;
        // Registered phase is zero straight out of reset; ignore it until loaded once.
        phase_bad = primed_q & ~((red_q ^ yellow_q ^ green_q) & ~(red_q & yellow_q & green_q));
        tick      = (pre_q == PRE_W'(TICK_DIV - 1));
`ifdef PED_AUTO_EN
        auto_go   = red_rise;
`else
        auto_go   = 1'b0;
`endif

        state_d = state_q;
        fault_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (auto_go)
                    state_d = S_WALK;
                else if (req_q)
                    state_d = S_WAIT_RED;
            end
            S_WAIT_RED: begin
                if (red_rise)
                    state_d = S_WALK;
            end
            S_WALK: begin
                if (!red_q) begin
                    state_d = S_IDLE;
                    fault_d = 1'b1;
                end else if (tick && (sec_q == SEC_W'(WALK_SECS - 1))) begin
                    state_d = S_FLASH;
                end
            end
            S_FLASH: begin
                if (!red_q) begin
                    state_d = S_IDLE;
                    fault_d = 1'b1;
                end else if (tick && (cnt_q == CNT_W'(1))) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (!red_q)
                    state_d = req_q ? S_WAIT_RED : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (phase_bad) begin
            state_d = S_IDLE;
            fault_d = 1'b1;
        end

        // Timers restart on every state entry so WALK/FLASH durations are exact.
        if ((state_d == state_q) && ((state_q == S_WALK) || (state_q == S_FLASH)))
            pre_d = tick ? '0 : pre_q + PRE_W'(1);
        else
            pre_d = '0;

        if ((state_d == S_WALK) && (state_q == S_WALK))
            sec_d = tick ? sec_q + SEC_W'(1) : sec_q;
        else
            sec_d = '0;

        if (state_d != S_FLASH)
            cnt_d = '0;
        else if (state_q != S_FLASH)
            cnt_d = CNT_W'(FLASH_SECS);
        else
            cnt_d = tick ? cnt_q - CNT_W'(1) : cnt_q;

        req_d = req_q;
        if ((state_d == S_WALK) && (state_q != S_WALK))
            req_d = 1'b0;
        else if (btn_edge && (state_q != S_WALK) && (state_q != S_FLASH))
            req_d = 1'b1;

        walk_d = (state_d == S_WALK);
        if (state_d == S_FLASH)
            dw_d = (pre_d < PRE_W'(TICK_DIV / 2));
        else
            dw_d = (state_d != S_WALK);
    end

    assign bus.walk      = walk_q;
    assign bus.dont_walk = dw_q;
    assign bus.ped_ack   = req_q;
    assign bus.countdown = cnt_q;
    assign bus.fault     = fault_q;
endmodule

// File: tb/tb_ped_signal_controller.sv
// Directed bench for ped_signal_controller (TICK_DIV=10, WALK_SECS=3, FLASH_SECS=2).
// Inputs change 1 ns after a rising edge; outputs are checked at that same point.
module tb_ped_signal_controller;
    localparam int TICK_DIV   = 10;
    localparam int WALK_SECS  = 3;
    localparam int FLASH_SECS = 2;
    localparam int CNT_W      = 4;

`ifdef PED_AUTO_EN
    localparam logic AUTO = 1'b1;
`else
    localparam logic AUTO = 1'b0;
`endif

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    ped_signal_controller_if #(.CNT_W(CNT_W)) bus ();

    ped_signal_controller #(
        .TICK_DIV   (TICK_DIV),
        .WALK_SECS  (WALK_SECS),
        .FLASH_SECS (FLASH_SECS),
        .CNT_W      (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic phase(input logic r, input logic y, input logic g);
        bus.red    = r;
        bus.yellow = y;
        bus.green  = g;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {walk, dont_walk, ped_ack, countdown, fault}
    function automatic logic [7:0] outs();
        return {bus.walk, bus.dont_walk, bus.ped_ack, bus.countdown, bus.fault};
    endfunction

    localparam logic [7:0] RST_OUTS = {1'b0, 1'b1, 1'b0, 4'd0, 1'b0};

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        phase(1'b0, 1'b0, 1'b1);
        bus.ped_btn = 1'b0;

        // Reset held: inputs toggling, outputs pinned at reset values.
        for (int i = 0; i < 6; i++) begin
            phase(i[0], i[1], ~i[0]);
            bus.ped_btn = i[2] ^ i[0];
            cyc(1);
            chk("reset_hold", outs(), RST_OUTS);
        end
        phase(1'b0, 1'b0, 1'b1);
        bus.ped_btn = 1'b0;
        cyc(1);
        reset = 1'b1;
        cyc(1);
        chk("post_reset_1", outs(), RST_OUTS);
        cyc(1);
        chk("post_reset_2", outs(), RST_OUTS);

        // Red rises with no request: walk only in the auto build.
        phase(1'b1, 1'b0, 1'b0);
        cyc(1);
        chk("no_req_walk_lag", bus.walk, 1'b0);
        cyc(1);
        chk("no_req_walk", bus.walk, AUTO);
        phase(1'b0, 1'b0, 1'b1);
        cyc(4);
        chk("idle_again", outs(), RST_OUTS);

        // Normal cycle: button during green.
        bus.ped_btn = 1'b1;
        cyc(2);
        chk("ack_lag", bus.ped_ack, 1'b0);
        cyc(1);
        chk("ack_3cyc", bus.ped_ack, 1'b1);
        bus.ped_btn = 1'b0;
        cyc(2);
        phase(1'b1, 1'b0, 1'b0);
        cyc(1);
        chk("walk_lag", bus.walk, 1'b0);
        cyc(1);
        chk("walk_entry", outs(), {1'b1, 1'b0, 1'b0, 4'd0, 1'b0});
        for (int i = 1; i < 30; i++) begin
            cyc(1);
            chk("walk_hold", {bus.walk, bus.dont_walk}, 2'b10);
        end
        cyc(1);
        chk("flash_entry", outs(), {1'b0, 1'b1, 1'b0, 4'd2, 1'b0});
        for (int j = 1; j < 20; j++) begin
            cyc(1);
            chk("flash", {bus.walk, bus.dont_walk, bus.countdown},
                {1'b0, ((j % 10) < 5), ((j < 10) ? 4'd2 : 4'd1)});
        end
        cyc(1);
        chk("clear_entry", outs(), {1'b0, 1'b1, 1'b0, 4'd0, 1'b0});

        // Late request: press while red is still high (CLEAR).
        bus.ped_btn = 1'b1;
        cyc(3);
        chk("late_ack", bus.ped_ack, 1'b1);
        bus.ped_btn = 1'b0;
        cyc(5);
        chk("late_no_walk", {bus.walk, bus.dont_walk}, 2'b01);
        phase(1'b0, 1'b0, 1'b1);
        cyc(5);
        chk("late_wait", {bus.walk, bus.ped_ack}, 2'b01);
        phase(1'b1, 1'b0, 1'b0);
        cyc(1);
        chk("late_walk_lag", bus.walk, 1'b0);
        cyc(1);
        chk("late_walk", {bus.walk, bus.ped_ack}, 2'b10);

        // Abort: red drops 10 cycles into WALK.
        cyc(10);
        chk("abort_pre", bus.walk, 1'b1);
        phase(1'b0, 1'b0, 1'b1);
        cyc(1);
        chk("abort_lag", {bus.walk, bus.fault}, 2'b10);
        cyc(1);
        chk("abort_hit", outs(), {1'b0, 1'b1, 1'b0, 4'd0, 1'b1});
        cyc(1);
        chk("abort_pulse_end", outs(), RST_OUTS);

        // Invalid phase with a pending request.
        bus.ped_btn = 1'b1;
        cyc(3);
        chk("inv_ack", bus.ped_ack, 1'b1);
        bus.ped_btn = 1'b0;
        cyc(1);
        phase(1'b1, 1'b0, 1'b1);
        cyc(1);
        chk("inv_lag", bus.fault, 1'b0);
        for (int k = 2; k <= 8; k++) begin
            cyc(1);
            chk("inv_hold", {bus.walk, bus.dont_walk, bus.ped_ack, bus.fault}, 4'b0111);
        end
        phase(1'b0, 1'b0, 1'b1);
        cyc(1);
        chk("inv_tail", {bus.walk, bus.ped_ack, bus.fault}, 3'b011);
        cyc(1);
        chk("inv_clear", {bus.walk, bus.ped_ack, bus.fault}, 3'b010);
        cyc(3);
        phase(1'b1, 1'b0, 1'b0);
        cyc(2);
        chk("inv_walk", {bus.walk, bus.ped_ack, bus.fault}, 3'b100);

        // Reset mid-FLASH, during the dark half of a tick.
        cyc(30);
        cyc(6);
        chk("mid_flash", outs(), {1'b0, 1'b0, 1'b0, 4'd2, 1'b0});
        reset = 1'b0;
        #1;
        chk("reset_mid_flash", outs(), RST_OUTS);
        phase(1'b0, 1'b0, 1'b1);
        cyc(1);
        reset = 1'b1;
        cyc(2);

        // Reset also drops a pending request.
        bus.ped_btn = 1'b1;
        cyc(3);
        chk("req_before_reset", bus.ped_ack, 1'b1);
        bus.ped_btn = 1'b0;
        reset = 1'b0;
        #1;
        chk("req_after_reset", outs(), RST_OUTS);
        cyc(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
